// File: rtl/vx_smem_pkg.sv
// Shared types, default geometry and the byte-enable merge used by the responder.
package vx_smem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_RSP   = 2'd2
  } smem_state_e;

  localparam int unsigned DEF_NUM_BANKS  = 4;
  localparam int unsigned DEF_SIZE_WORDS = 1024;
  localparam int unsigned BANK_SEL_BITS  = $clog2(DEF_NUM_BANKS);
  localparam int unsigned ROW_BITS       = $clog2(DEF_SIZE_WORDS / DEF_NUM_BANKS);

  // Replace only the bytes selected by byteen; the rest keep the old value.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  byteen);
    logic [31:0] merged;
    merged = old_word;
    for (int unsigned k = 0; k < 4; k++) begin
      if (byteen[k]) merged[k*8 +: 8] = new_word[k*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/vx_smem_bank.sv
// One shared-memory bank: byte-enabled synchronous write, combinational read.
module vx_smem_bank
  import vx_smem_pkg::*;
#(
  parameter int unsigned ROWS  = 256,
  parameter int unsigned ROW_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       byteen,
  input  logic [ROW_W-1:0] row,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata_c
);

  logic [31:0] mem_q [ROWS];

  // Write path: merge enabled bytes into the addressed row.
  always_ff @(posedge clk) begin
    if (we) mem_q[row] <= byte_merge(mem_q[row], wdata, byteen);
  end

  assign rdata_c = mem_q[row];

endmodule

// File: rtl/vx_smem_responder.sv
// Banked shared-memory responder: serializes bank conflicts, returns one read response per batch.
module vx_smem_responder
  import vx_smem_pkg::*;
#(
  parameter int unsigned NUM_REQS   = 4,
  parameter int unsigned NUM_BANKS  = DEF_NUM_BANKS,
  parameter int unsigned SIZE_WORDS = DEF_SIZE_WORDS,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS-1:0]       req_rw,
  input  logic [NUM_REQS*4-1:0]     req_byteen,
  input  logic [NUM_REQS*30-1:0]    req_addr,
  input  logic [NUM_REQS*32-1:0]    req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0] req_tag,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic [NUM_REQS-1:0]       rsp_valid,
  output logic [NUM_REQS*32-1:0]    rsp_data,
  output logic [TAG_WIDTH-1:0]      rsp_tag,
  input  logic                      rsp_ready,
  output logic                      busy,
  output logic [31:0]               conflict_cycles
);

  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned ROWS   = SIZE_WORDS / NUM_BANKS;
  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  smem_state_e state_q, state_d;
  logic [NUM_REQS-1:0]    pend_q, pend_d;
  logic [NUM_REQS-1:0]    rdmask_q, rdmask_d;
  logic [NUM_REQS-1:0]    rw_q, rw_d;
  logic [3:0]             be_q [NUM_REQS];
  logic [3:0]             be_d [NUM_REQS];
  logic [29:0]            addr_q [NUM_REQS];
  logic [29:0]            addr_d [NUM_REQS];
  logic [31:0]            data_q [NUM_REQS];
  logic [31:0]            data_d [NUM_REQS];
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic                   first_q, first_d;
  logic [31:0]            conf_q, conf_d;
  logic [NUM_REQS*32-1:0] rsp_data_q, rsp_data_d;
  logic [NUM_REQS-1:0]    rsp_valid_q, rsp_valid_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   tag_found;

  logic [BANK_W-1:0]      lane_bank [NUM_REQS];
  logic [ROW_W-1:0]       lane_row [NUM_REQS];
  logic [NUM_REQS-1:0]    grant;
  logic                   serve_en;

  logic [NUM_BANKS-1:0]   bank_we;
  logic [3:0]             bank_be [NUM_BANKS];
  logic [ROW_W-1:0]       bank_row [NUM_BANKS];
  logic [31:0]            bank_wdata [NUM_BANKS];
  logic [31:0]            bank_rdata [NUM_BANKS];

  // Bank / row decode of each captured lane address; upper bits wrap away.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      lane_bank[i] = BANK_W'(addr_q[i] % 30'(NUM_BANKS));
      lane_row[i]  = ROW_W'((addr_q[i] / 30'(NUM_BANKS)) % 30'(ROWS));
    end
  end

  // No bank write may land on the cycle reset is sampled.
  assign serve_en = (state_q == ST_SERVE) && !reset;

  // Per-bank grant to the lowest pending lane, then steer that lane onto its bank.
  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      grant[i] = serve_en && pend_q[i];
      for (int unsigned j = 0; j < i; j++) begin
        if (pend_q[j] && (lane_bank[j] == lane_bank[i])) grant[i] = 1'b0;
      end
    end
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_we[b]    = 1'b0;
      bank_be[b]    = '0;
      bank_row[b]   = '0;
      bank_wdata[b] = '0;
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
        if (grant[i] && (lane_bank[i] == BANK_W'(b))) begin
          bank_we[b]    = rw_q[i];
          bank_be[b]    = be_q[i];
          bank_row[b]   = lane_row[i];
          bank_wdata[b] = data_q[i];
        end
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    vx_smem_bank #(
      .ROWS  (ROWS),
      .ROW_W (ROW_W)
    ) u_bank (
      .clk     (clk),
      .we      (bank_we[b]),
      .byteen  (bank_be[b]),
      .row     (bank_row[b]),
      .wdata   (bank_wdata[b]),
      .rdata_c (bank_rdata[b])
    );
  end

  // Next-state, batch capture, read latching, conflict counting and output decode.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    rdmask_d   = rdmask_q;
    rw_d       = rw_q;
    be_d       = be_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tag_d      = tag_q;
    first_d    = first_q;
    conf_d     = conf_q;
    rsp_data_d = rsp_data_q;
    tag_found  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          pend_d   = req_valid;
          rdmask_d = req_valid & ~req_rw;
          rw_d     = req_rw;
          for (int unsigned i = 0; i < NUM_REQS; i++) begin
            be_d[i]   = req_byteen[i*4 +: 4];
            addr_d[i] = req_addr[i*30 +: 30];
            data_d[i] = req_data[i*32 +: 32];
            if (req_valid[i] && !tag_found) begin
              tag_d     = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
              tag_found = 1'b1;
            end
          end
          first_d = 1'b1;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        first_d = 1'b0;
        if (!first_q) conf_d = conf_q + 32'd1;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
          if (grant[i]) begin
            pend_d[i] = 1'b0;
            if (!rw_q[i]) rsp_data_d[i*32 +: 32] = bank_rdata[lane_bank[i]];
          end
        end
        if (pend_d == '0) state_d = (rdmask_q != '0) ? ST_RSP : ST_IDLE;
      end
      ST_RSP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rsp_valid_d = (state_d == ST_RSP) ? rdmask_d : '0;
    ready_d     = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      rdmask_q    <= '0;
      tag_q       <= '0;
      first_q     <= 1'b0;
      conf_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      rdmask_q    <= rdmask_d;
      tag_q       <= tag_d;
      first_q     <= first_d;
      conf_q      <= conf_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  // Batch payload; only meaningful while pending bits are set, so no reset.
  always_ff @(posedge clk) begin
    rw_q   <= rw_d;
    be_q   <= be_d;
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign req_ready       = {NUM_REQS{ready_q}};
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_tag         = tag_q;
  assign busy            = busy_q;
  assign conflict_cycles = conf_q;

endmodule

// File: tb/tb_vx_smem_responder.sv
// Directed bench for vx_smem_responder: 4 lanes, 4 banks, 1024 words, 8-bit tags.
module tb_vx_smem_responder;
  import vx_smem_pkg::*;

  localparam int unsigned NR     = 4;
  localparam int unsigned TW     = 8;
  localparam int unsigned STRIDE = 1 << BANK_SEL_BITS;
  localparam int unsigned WRAP   = 1 << (BANK_SEL_BITS + ROW_BITS);

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid, req_rw, req_ready, rsp_valid;
  logic [NR*4-1:0]  req_byteen;
  logic [NR*30-1:0] req_addr;
  logic [NR*32-1:0] req_data, rsp_data;
  logic [NR*TW-1:0] req_tag;
  logic [TW-1:0]    rsp_tag;
  logic             rsp_ready, busy;
  logic [31:0]      conflict_cycles;

  int checks = 0;
  int errors = 0;
  int exp_conf = 0;

  logic [NR-1:0] l_v, l_rw;
  logic [3:0]    l_be [NR];
  logic [29:0]   l_ad [NR];
  logic [31:0]   l_wd [NR];
  logic [TW-1:0] l_tg [NR];

  vx_smem_responder #(
    .NUM_REQS(NR), .NUM_BANKS(4), .SIZE_WORDS(1024), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw),
    .req_byteen(req_byteen), .req_addr(req_addr), .req_data(req_data),
    .req_tag(req_tag), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
    .busy(busy), .conflict_cycles(conflict_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int i);
    return rsp_data[i*32 +: 32];
  endfunction

  task automatic clear_lanes();
    l_v = '0;
    l_rw = '0;
    for (int i = 0; i < NR; i++) begin
      l_be[i] = 4'hF; l_ad[i] = '0; l_wd[i] = '0; l_tg[i] = '0;
    end
  endtask

  task automatic set_lane(input int i, input logic rw, input logic [29:0] a,
                          input logic [31:0] d, input logic [3:0] be, input logic [TW-1:0] t);
    l_v[i] = 1'b1; l_rw[i] = rw; l_ad[i] = a; l_wd[i] = d; l_be[i] = be; l_tg[i] = t;
  endtask

  task automatic drive_lanes();
    req_valid = l_v;
    req_rw    = l_rw;
    for (int i = 0; i < NR; i++) begin
      req_byteen[i*4 +: 4]   = l_be[i];
      req_addr[i*30 +: 30]   = l_ad[i];
      req_data[i*32 +: 32]   = l_wd[i];
      req_tag[i*TW +: TW]    = l_tg[i];
    end
  endtask

  // Issue the staged batch, count serve cycles, check response-or-idle state.
  task automatic run_batch(input string name, input int exp_k,
                           input logic [NR-1:0] exp_mask, input logic [TW-1:0] exp_tag);
    int n;
    @(negedge clk);
    chk({name, "_rdy_in"}, 64'(req_ready), 64'hF);
    drive_lanes();
    @(posedge clk); #1;
    req_valid = '0;
    chk({name, "_rdy_busy"}, 64'(req_ready), 64'h0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && rsp_valid == '0 && n < 20);
    if (exp_k > 1) exp_conf += exp_k - 1;
    chk({name, "_serve"}, 64'(n), 64'(exp_k));
    chk({name, "_mask"}, 64'(rsp_valid), 64'(exp_mask));
    chk({name, "_busy"}, 64'(busy), 64'(exp_mask != '0));
    chk({name, "_conf"}, 64'(conflict_cycles), 64'(exp_conf));
    if (exp_mask != '0) chk({name, "_tag"}, 64'(rsp_tag), 64'(exp_tag));
  endtask

  task automatic take_rsp(input string name);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({name, "_done_valid"}, 64'(rsp_valid), 64'h0);
    chk({name, "_done_busy"}, 64'(busy), 64'h0);
    chk({name, "_done_rdy"}, 64'(req_ready), 64'hF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req_valid = '0; req_rw = '0; req_byteen = '0; req_addr = '0; req_data = '0; req_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'hF);
    chk("rst_valid", 64'(rsp_valid), 64'h0);
    chk("rst_data", 64'(rsp_data[63:0]), 64'h0);
    chk("rst_tag", 64'(rsp_tag), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_conf", 64'(conflict_cycles), 64'h0);

    // Single-lane write then readback.
    clear_lanes(); set_lane(0, 1'b1, 30'h10, 32'hDEADBEEF, 4'hF, 8'h01);
    run_batch("wr10", 1, 4'b0000, 8'h00);
    clear_lanes(); set_lane(0, 1'b0, 30'h10, 32'h0, 4'hF, 8'h05);
    run_batch("rd10", 1, 4'b0001, 8'h05);
    chk("rd10_data", 64'(rd(0)), 64'hDEADBEEF);
    take_rsp("rd10");

    // Preload: same-bank write batch (4 conflicts), then lanes 1..3 to distinct banks.
    clear_lanes();
    for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 30'(i * STRIDE), 32'hB0 + 32'(i), 4'hF, 8'h10 + 8'(i));
    run_batch("wrconf", 4, 4'b0000, 8'h00);
    clear_lanes();
    for (int i = 1; i < 4; i++) set_lane(i, 1'b1, 30'(i), 32'hC0 + 32'(i), 4'hF, 8'h18 + 8'(i));
    run_batch("wr123", 1, 4'b0000, 8'h00);

    // Conflict-free read.
    clear_lanes();
    for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 30'(i), 32'h0, 4'h0, 8'h21 + 8'(i));
    run_batch("rdfree", 1, 4'b1111, 8'h21);
    chk("rdfree_d0", 64'(rd(0)), 64'hB0);
    chk("rdfree_d1", 64'(rd(1)), 64'hC1);
    chk("rdfree_d2", 64'(rd(2)), 64'hC2);
    chk("rdfree_d3", 64'(rd(3)), 64'hC3);
    take_rsp("rdfree");

    // Full conflict read.
    clear_lanes();
    for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 30'(i * STRIDE), 32'h0, 4'hF, 8'h31 + 8'(i));
    run_batch("rdconf", 4, 4'b1111, 8'h31);
    chk("rdconf_d0", 64'(rd(0)), 64'hB0);
    chk("rdconf_d1", 64'(rd(1)), 64'hB1);
    chk("rdconf_d2", 64'(rd(2)), 64'hB2);
    chk("rdconf_d3", 64'(rd(3)), 64'hB3);
    take_rsp("rdconf");

    // Partial write seen by a higher lane of the same batch.
    clear_lanes(); set_lane(0, 1'b1, 30'h8, 32'h11223344, 4'hF, 8'h40);
    run_batch("pre8", 1, 4'b0000, 8'h00);
    clear_lanes();
    set_lane(0, 1'b1, 30'h8, 32'hAAAABBBB, 4'h3, 8'h41);
    set_lane(1, 1'b0, 30'h8, 32'h0, 4'hF, 8'h42);
    run_batch("part", 2, 4'b0010, 8'h41);
    chk("part_d1", 64'(rd(1)), 64'h1122BBBB);
    take_rsp("part");

    // Lower-lane read must not see a higher-lane write.
    clear_lanes();
    set_lane(0, 1'b0, 30'h8, 32'h0, 4'hF, 8'h43);
    set_lane(1, 1'b1, 30'h8, 32'hFFFFFFFF, 4'hF, 8'h44);
    run_batch("order", 2, 4'b0001, 8'h43);
    chk("order_d0", 64'(rd(0)), 64'h1122BBBB);
    take_rsp("order");
    clear_lanes(); set_lane(2, 1'b0, 30'h8, 32'h0, 4'hF, 8'h45);
    run_batch("rd8", 1, 4'b0100, 8'h45);
    chk("rd8_d2", 64'(rd(2)), 64'hFFFFFFFF);
    take_rsp("rd8");

    // Zero-byteen write occupies a slot; a wrapped address hits the same word.
    clear_lanes();
    set_lane(0, 1'b1, 30'h10, 32'h0, 4'h0, 8'h46);
    set_lane(1, 1'b0, 30'h10, 32'h0, 4'hF, 8'h47);
    set_lane(2, 1'b0, 30'(32'h10 + WRAP), 32'h0, 4'hF, 8'h48);
    run_batch("be0wrap", 3, 4'b0110, 8'h46);
    chk("be0_d1", 64'(rd(1)), 64'hDEADBEEF);
    chk("wrap_d2", 64'(rd(2)), 64'hDEADBEEF);
    take_rsp("be0wrap");

    // Backpressure: response holds, stray requests ignored while not idle.
    clear_lanes();
    set_lane(0, 1'b0, 30'h1, 32'h0, 4'hF, 8'h51);
    set_lane(2, 1'b0, 30'h10, 32'h0, 4'hF, 8'h52);
    run_batch("bp", 1, 4'b0101, 8'h51);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) begin
        req_valid = 4'hF; req_rw = 4'hF; req_data = '0;
      end
      @(posedge clk); #1;
      chk("bp_valid", 64'(rsp_valid), 64'h5);
      chk("bp_d0", 64'(rd(0)), 64'hC1);
      chk("bp_d2", 64'(rd(2)), 64'hDEADBEEF);
      chk("bp_tag", 64'(rsp_tag), 64'h51);
      chk("bp_rdy", 64'(req_ready), 64'h0);
    end
    @(negedge clk); req_valid = '0;
    take_rsp("bp");
    clear_lanes(); set_lane(0, 1'b0, 30'h1, 32'h0, 4'hF, 8'h53);
    run_batch("bpchk", 1, 4'b0001, 8'h53);
    chk("bpchk_d0", 64'(rd(0)), 64'hC1);
    take_rsp("bpchk");

    // Reset during a 4-conflict write batch after two lanes were served.
    clear_lanes();
    for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 30'(32'h20 + 32'(i) * STRIDE), 32'hD0 + 32'(i), 4'hF, 8'h60);
    @(negedge clk);
    drive_lanes();
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_conf", 64'(conflict_cycles), 64'h0);
    chk("mid_rst_rdy", 64'(req_ready), 64'hF);
    @(negedge clk); reset = 1'b0;
    exp_conf = 0;
    clear_lanes();
    set_lane(0, 1'b0, 30'h20, 32'h0, 4'hF, 8'h61);
    set_lane(1, 1'b0, 30'(32'h20 + STRIDE), 32'h0, 4'hF, 8'h62);
    run_batch("postrst", 2, 4'b0011, 8'h61);
    chk("postrst_d0", 64'(rd(0)), 64'hD0);
    chk("postrst_d1", 64'(rd(1)), 64'hD1);
    take_rsp("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
